alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
//  Issue/sequencing front end for the combinational 8-bit ALU: accepts one op request, drives ALU OP/INPUTA/INPUTB/SC_IN,
//  captures OUT/SC_OUT/ZERO, holds the architectural carry flag and returns a registered result via valid/ready.
//  Executes multi-bit shifts (ksfli/ksfri/ksfrr) as 1-bit steps over several cycles. Sits between decode and writeback.
// PARAMETERS
//  DW        8   datapath width (only 8 supported)
//  SHAMT_MAX 8   shift counts above this clamp to SHAMT_MAX
// PORTS
//  CLK            in   1  clock, rising edge
//  RESET_N        in   1  asynchronous, active-low reset
//  REQ_VALID      in   1  request present
//  REQ_READY      out  1  block can accept (IDLE only)
//  REQ_OP         in   5  opcode (op_mne values from definitions)
//  REQ_A          in   8  operand A
//  REQ_B          in   8  operand B / shift count (B[3:0])
//  REQ_USE_CARRY  in   1  1: SC_IN=CARRY_FLAG for ALU ops; 0: SC_IN=0
//  ALU_OP         out  5  to ALU OP
//  ALU_A / ALU_B  out  8  to ALU INPUTA / INPUTB
//  ALU_SC_IN      out  1  to ALU SC_IN
//  ALU_OUT        in   8  from ALU OUT
//  ALU_SC_OUT     in   1  from ALU SC_OUT
//  ALU_ZERO       in   1  from ALU ZERO
//  RES_VALID      out  1  result held valid
//  RES_READY      in   1  consumer takes result
//  RES_DATA       out  8  result byte
//  RES_CARRY      out  1  carry/last bit shifted out
//  RES_ZERO       out  1  RES_DATA==0
//  CARRY_FLAG     out  1  architectural carry register
// BEHAVIOUR
//  Reset (async, RESET_N=0): state=IDLE; REQ_READY=1; RES_VALID/RES_DATA/RES_CARRY/RES_ZERO/CARRY_FLAG=0; ALU_* =0.
//   Reset mid-operation aborts immediately; in-flight request is dropped, no result produced.
//  FSM: IDLE, EXEC, SHIFT, RESP.
//  IDLE: REQ_READY=1. Handshake = REQ_VALID&REQ_READY at edge; latch op,A,B,use_carry.
//   non-shift op      -> EXEC
//   shift, cnt==0     -> RESP; RES_DATA=A, RES_CARRY=0, RES_ZERO=(A==0)
//   shift, cnt>0      -> SHIFT; cnt=min(B[3:0],SHAMT_MAX); work=A
//  EXEC (1 cycle): ALU_OP=op, ALU_A=A, ALU_B=B, ALU_SC_IN=use_carry?CARRY_FLAG:0; capture ALU_OUT/SC_OUT/ZERO -> RESP.
//  SHIFT (cnt cycles):
//   ksfli: ALU_OP=kaddi, ALU_A=ALU_B=work, ALU_SC_IN=0; work<=ALU_OUT, carry<=ALU_SC_OUT (doubling = shl 1).
//   ksfri/ksfrr: local logical right shift; work<=work>>1, carry<=work[0]; ALU_OP=kmov, ALU_A=work.
//   cnt decrements each cycle; on cnt==1 step -> RESP with RES_DATA=new work, RES_ZERO=(new work==0).
//  RESP: RES_VALID=1; RES_* stable until RES_READY=1 at an edge -> IDLE. REQ_READY=0 (no accept in RESP).
//  CARRY_FLAG updated with RES_CARRY on the edge entering RESP (all ops, incl. cnt==0 -> 0).
//  Latency accept->RES_VALID: ALU op 2 edges; shift n (1..8) n+1 edges; cnt==0 1 edge. Throughput >=1 op / (latency+1).
//  Width: 8-bit data, 9-bit {carry,data} from ALU; no internal arithmetic beyond cnt (4-bit) and 1-bit right shift.
//  Outside EXEC/SHIFT, ALU_OP=kmov, ALU_A=ALU_B=0, ALU_SC_IN=0 (quiet bus).
// STRUCTURE
//  definitions package: add typedef enum logic[1:0] {S_IDLE,S_EXEC,S_SHIFT,S_RESP} seq_state_t; localparam SHAMT_MAX=8;
//   reuse op_mne (kaddi,kmov,ksfli,ksfri,ksfrr) and add function is_shift(op).
//  Single module; no sub-module. Bench instantiates ALU alongside and wires ALU_* ports.
// TESTING
//  1 kaddi A=F0 B=20 use_carry=0 -> RES_DATA=10 RES_CARRY=1 RES_ZERO=0, RES_VALID 2 edges after accept, CARRY_FLAG=1.
//  2 then kaddi A=01 B=01 use_carry=1 -> RES_DATA=03 RES_CARRY=0, CARRY_FLAG=0.
//  3 ksfli A=B3 B=3 -> RES_DATA=98 RES_CARRY=1, RES_VALID 4 edges after accept; ALU_OP=kaddi during SHIFT.
//  4 ksfri A=B3 B=2 -> 2C carry 1; ksfrr A=80 B=C (clamp 8) -> 00 carry 1 RES_ZERO=1.
//  5 ksfli A=5A B=0 -> 5A carry 0, RES_VALID 1 edge after accept.
//  6 RES_READY=0 for 5 cycles -> RES_* stable, REQ_READY=0; RESET_N low mid-SHIFT -> IDLE, RES_VALID=0, CARRY_FLAG=0 at once.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: opcode mnemonics, FSM states
// and small decode helpers.
package alu_issue_seq_pkg;

   localparam int DW        = 8;
   localparam int SHAMT_MAX = 8;

   typedef enum logic [4:0] {
      kmov  = 5'd0,
      kaddi = 5'd1,
      ksubi = 5'd2,
      kand  = 5'd3,
      kor   = 5'd4,
      kxor  = 5'd5,
      ksfli = 5'd6,
      ksfri = 5'd7,
      ksfrr = 5'd8
   } op_mne;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_RESP} seq_state_t;

   function automatic logic is_shift(input logic [4:0] op);
      return (op == ksfli) || (op == ksfri) || (op == ksfrr);
   endfunction

   function automatic logic [3:0] clamp_cnt(input logic [3:0] b);
      return (b > 4'(SHAMT_MAX)) ? 4'(SHAMT_MAX) : b;
   endfunction

endpackage

// File: rtl/alu_issue_seq.sv
// Issue/sequencing front end for the combinational 8-bit ALU: single-op issue,
// multi-cycle 1-bit shift stepping, architectural carry flag, valid/ready result.
module alu_issue_seq
   import alu_issue_seq_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [4:0]       REQ_OP,
   input  logic [DW-1:0]    REQ_A,
   input  logic [DW-1:0]    REQ_B,
   input  logic             REQ_USE_CARRY,
   output logic [4:0]       ALU_OP,
   output logic [DW-1:0]    ALU_A,
   output logic [DW-1:0]    ALU_B,
   output logic             ALU_SC_IN,
   input  logic [DW-1:0]    ALU_OUT,
   input  logic             ALU_SC_OUT,
   input  logic             ALU_ZERO,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [DW-1:0]    RES_DATA,
   output logic             RES_CARRY,
   output logic             RES_ZERO,
   output logic             CARRY_FLAG,
   output seq_state_t       DBG_STATE
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; requests are taken only in IDLE, results are held in RESP until taken.

   seq_state_t    r_state;
   logic [4:0]    r_op;
   logic [3:0]    r_cnt;
   logic [DW-1:0] r_work;
   logic [4:0]    r_alu_op;
   logic [DW-1:0] r_alu_a;
   logic [DW-1:0] r_alu_b;
   logic          r_alu_sc_in;
   logic [DW-1:0] r_res_data;
   logic          r_res_carry;
   logic          r_res_zero;
   logic          r_carry_flag;

   logic [DW-1:0] w_next_work;
   logic          w_next_carry;
   logic          w_is_sfl;

   // Left shifts ride on the ALU adder (x+x); right shifts are done locally.
   assign w_is_sfl     = (r_op == ksfli);
   assign w_next_work  = w_is_sfl ? ALU_OUT    : {1'b0, r_work[DW-1:1]};
   assign w_next_carry = w_is_sfl ? ALU_SC_OUT : r_work[0];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= S_IDLE;
         r_op         <= kmov;
         r_cnt        <= '0;
         r_work       <= '0;
         r_alu_op     <= kmov;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_sc_in  <= 1'b0;
         r_res_data   <= '0;
         r_res_carry  <= 1'b0;
         r_res_zero   <= 1'b0;
         r_carry_flag <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (REQ_VALID) begin
                  r_op <= REQ_OP;
                  if (!is_shift(REQ_OP)) begin
                     r_state     <= S_EXEC;
                     r_alu_op    <= REQ_OP;
                     r_alu_a     <= REQ_A;
                     r_alu_b     <= REQ_B;
                     r_alu_sc_in <= REQ_USE_CARRY & r_carry_flag;
                  end else if (REQ_B[3:0] == 4'd0) begin
                     r_state      <= S_RESP;
                     r_res_data   <= REQ_A;
                     r_res_carry  <= 1'b0;
                     r_res_zero   <= (REQ_A == '0);
                     r_carry_flag <= 1'b0;
                  end else begin
                     r_state     <= S_SHIFT;
                     r_cnt       <= clamp_cnt(REQ_B[3:0]);
                     r_work      <= REQ_A;
                     r_alu_a     <= REQ_A;
                     r_alu_sc_in <= 1'b0;
                     if (REQ_OP == ksfli) begin
                        r_alu_op <= kaddi;
                        r_alu_b  <= REQ_A;
                     end else begin
                        r_alu_op <= kmov;
                        r_alu_b  <= '0;
                     end
                  end
               end
            end
            S_EXEC: begin
               r_state      <= S_RESP;
               r_res_data   <= ALU_OUT;
               r_res_carry  <= ALU_SC_OUT;
               r_res_zero   <= ALU_ZERO;
               r_carry_flag <= ALU_SC_OUT;
               r_alu_op     <= kmov;
               r_alu_a      <= '0;
               r_alu_b      <= '0;
               r_alu_sc_in  <= 1'b0;
            end
            S_SHIFT: begin
               r_work <= w_next_work;
               r_cnt  <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state      <= S_RESP;
                  r_res_data   <= w_next_work;
                  r_res_carry  <= w_next_carry;
                  r_res_zero   <= (w_next_work == '0);
                  r_carry_flag <= w_next_carry;
                  r_alu_op     <= kmov;
                  r_alu_a      <= '0;
                  r_alu_b      <= '0;
               end else begin
                  r_alu_a <= w_next_work;
                  r_alu_b <= w_is_sfl ? w_next_work : '0;
               end
            end
            S_RESP: begin
               if (RES_READY) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign REQ_READY  = (r_state == S_IDLE);
   assign RES_VALID  = (r_state == S_RESP);
   assign ALU_OP     = r_alu_op;
   assign ALU_A      = r_alu_a;
   assign ALU_B      = r_alu_b;
   assign ALU_SC_IN  = r_alu_sc_in;
   assign RES_DATA   = r_res_data;
   assign RES_CARRY  = r_res_carry;
   assign RES_ZERO   = r_res_zero;
   assign CARRY_FLAG = r_carry_flag;
   assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural 8-bit ALU wired to its ALU_* bus.
module tb_alu_issue_seq;
   import alu_issue_seq_pkg::*;

   logic       CLK;
   logic       RESET_N;
   logic       REQ_VALID;
   logic       REQ_READY;
   logic [4:0] REQ_OP;
   logic [7:0] REQ_A;
   logic [7:0] REQ_B;
   logic       REQ_USE_CARRY;
   logic [4:0] ALU_OP;
   logic [7:0] ALU_A;
   logic [7:0] ALU_B;
   logic       ALU_SC_IN;
   logic [7:0] ALU_OUT;
   logic       ALU_SC_OUT;
   logic       ALU_ZERO;
   logic       RES_VALID;
   logic       RES_READY;
   logic [7:0] RES_DATA;
   logic       RES_CARRY;
   logic       RES_ZERO;
   logic       CARRY_FLAG;
   seq_state_t DBG_STATE;

   int n_checks = 0;
   int n_errors = 0;
   int lat;
   logic [4:0] first_alu_op;
   logic [7:0] first_alu_a;

   alu_issue_seq dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_USE_CARRY(REQ_USE_CARRY),
      .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SC_IN(ALU_SC_IN),
      .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT), .ALU_ZERO(ALU_ZERO),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
      .RES_CARRY(RES_CARRY), .RES_ZERO(RES_ZERO), .CARRY_FLAG(CARRY_FLAG),
      .DBG_STATE(DBG_STATE)
   );

   // Behavioural combinational ALU
   always_comb begin
      logic [8:0] w_res;
      w_res = '0;
      case (ALU_OP)
         kaddi:   w_res = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_SC_IN};
         ksubi:   w_res = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'd0, ALU_SC_IN};
         kand:    w_res = {1'b0, ALU_A & ALU_B};
         kor:     w_res = {1'b0, ALU_A | ALU_B};
         kxor:    w_res = {1'b0, ALU_A ^ ALU_B};
         default: w_res = {1'b0, ALU_A};
      endcase
      ALU_OUT    = w_res[7:0];
      ALU_SC_OUT = w_res[8];
      ALU_ZERO   = (w_res[7:0] == 8'd0);
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request, then count edges (accept edge = 1) until RES_VALID.
   task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic uc);
      @(negedge CLK);
      check("req_ready_idle", REQ_READY, 1'b1);
      REQ_OP = op; REQ_A = a; REQ_B = b; REQ_USE_CARRY = uc; REQ_VALID = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      lat = 1;
      first_alu_op = ALU_OP;
      first_alu_a  = ALU_A;
      while (!RES_VALID && lat < 20) begin
         @(posedge CLK); #1;
         lat++;
      end
      check("res_valid_timeout", RES_VALID, 1'b1);
   endtask

   task automatic expect_res(input string tag, input logic [7:0] d, input logic c,
                             input logic z, input int l);
      check({tag, "_data"}, RES_DATA, d);
      check({tag, "_carry"}, RES_CARRY, c);
      check({tag, "_zero"}, RES_ZERO, z);
      check({tag, "_flag"}, CARRY_FLAG, c);
      check({tag, "_lat"}, lat, l);
   endtask

   task automatic release_res();
      @(negedge CLK);
      RES_READY = 1'b1;
      @(posedge CLK); #1;
      RES_READY = 1'b0;
      check("release_valid", RES_VALID, 1'b0);
      check("release_ready", REQ_READY, 1'b1);
   endtask

   initial begin
      RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_OP = '0; REQ_A = '0; REQ_B = '0;
      REQ_USE_CARRY = 1'b0; RES_READY = 1'b0;
      #3;
      check("rst_req_ready", REQ_READY, 1'b1);
      check("rst_res_valid", RES_VALID, 1'b0);
      check("rst_res_data", RES_DATA, 8'h00);
      check("rst_flag", CARRY_FLAG, 1'b0);
      check("rst_alu_op", ALU_OP, 5'd0);
      check("rst_state", DBG_STATE, S_IDLE);
      @(negedge CLK); RESET_N = 1'b1;

      // 1: kaddi F0+20 -> 10, carry out
      run_op(kaddi, 8'hF0, 8'h20, 1'b0);
      check("t1_exec_op", first_alu_op, kaddi);
      check("t1_exec_a", first_alu_a, 8'hF0);
      expect_res("t1", 8'h10, 1'b1, 1'b0, 2);
      release_res();

      // 2: kaddi 01+01+carry flag(1) -> 03
      run_op(kaddi, 8'h01, 8'h01, 1'b1);
      expect_res("t2", 8'h03, 1'b0, 1'b0, 2);
      release_res();

      // 3: ksfli B3 by 3 -> 98 carry 1
      run_op(ksfli, 8'hB3, 8'h03, 1'b0);
      check("t3_shift_op", first_alu_op, kaddi);
      expect_res("t3", 8'h98, 1'b1, 1'b0, 4);
      check("t3_quiet_op", ALU_OP, kmov);
      release_res();

      // 4: right shifts, including count clamp
      run_op(ksfri, 8'hB3, 8'h02, 1'b0);
      check("t4a_shift_op", first_alu_op, kmov);
      expect_res("t4a", 8'h2C, 1'b1, 1'b0, 3);
      release_res();
      run_op(ksfrr, 8'h80, 8'h0C, 1'b0);
      expect_res("t4b", 8'h00, 1'b1, 1'b1, 9);
      release_res();

      // 5: zero-count shift passes A through
      run_op(ksfli, 8'h5A, 8'h00, 1'b0);
      expect_res("t5", 8'h5A, 1'b0, 1'b0, 1);
      release_res();

      // 6a: result held under backpressure, no accept while in RESP
      run_op(kaddi, 8'h80, 8'h80, 1'b0);
      expect_res("t6", 8'h00, 1'b1, 1'b1, 2);
      REQ_OP = kaddi; REQ_A = 8'h11; REQ_B = 8'h22; REQ_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         check("hold_valid", RES_VALID, 1'b1);
         check("hold_data", RES_DATA, 8'h00);
         check("hold_carry", RES_CARRY, 1'b1);
         check("hold_req_ready", REQ_READY, 1'b0);
      end
      REQ_VALID = 1'b0;
      release_res();

      // 6b: reset in the middle of a shift aborts at once
      run_op(ksfli, 8'hFF, 8'h00, 1'b0);
      release_res();
      run_op(kaddi, 8'hF0, 8'h20, 1'b0);
      release_res();
      @(negedge CLK);
      REQ_OP = ksfli; REQ_A = 8'hFF; REQ_B = 8'h08; REQ_VALID = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      @(posedge CLK); #1;
      check("mid_state", DBG_STATE, S_SHIFT);
      check("mid_flag", CARRY_FLAG, 1'b1);
      #2 RESET_N = 1'b0;
      #1;
      check("abort_state", DBG_STATE, S_IDLE);
      check("abort_valid", RES_VALID, 1'b0);
      check("abort_flag", CARRY_FLAG, 1'b0);
      check("abort_ready", REQ_READY, 1'b1);
      check("abort_alu_op", ALU_OP, 5'd0);
      @(negedge CLK); RESET_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("post_abort_valid", RES_VALID, 1'b0);

      run_op(kaddi, 8'h01, 8'h02, 1'b1);
      expect_res("post", 8'h03, 1'b0, 1'b0, 2);
      release_res();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
